spm_stream_ctrl: RTL and testbench



---
 rtl/spm_pkg.sv | 23 ++
 rtl/spm_rr_ptr.sv | 28 ++
 rtl/spm_stream_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spm_stream_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared types for the scratchpad stream controller: distribution modes,
// per-direction FSM states and the channel-select width helper.
package spm_pkg;

    typedef enum logic [1:0] {
        DIST_FIXED = 2'd0,
        DIST_RR    = 2'd1,
        DIST_BCAST = 2'd2,
        DIST_RSVD  = 2'd3
    } dist_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stream_state_e;

    // Channel selects stay at least one bit wide so single-channel builds elaborate.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spm_rr_ptr.sv
// Channel pointer: loads a start channel, then steps round-robin over
// channels 0..N-1 (N need not be a power of two).
module spm_rr_ptr
    import spm_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [sel_width(N)-1:0]   load_val,
    input  logic                      advance,
    output logic [sel_width(N)-1:0]   ptr
);

    localparam int unsigned W = sel_width(N);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (advance) begin
            ptr <= (ptr >= W'(N - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/spm_stream_ctrl.sv
// Streams bus-side words into mesh ingress FIFOs (fixed / round-robin /
// broadcast) and gathers egress FIFO words back to the bus side.
module spm_stream_ctrl
    import spm_pkg::*;
#(
    parameter int unsigned NUM_INGRESS_PE = 2,
    parameter int unsigned NUM_EGRESS_PE  = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PID_WIDTH      = 4,
    parameter int unsigned FIFO_WIDTH     = DATA_WIDTH + PID_WIDTH,
    parameter int unsigned CNT_WIDTH      = 9
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_start,
    input  logic                                  cfg_abort,
    input  logic [CNT_WIDTH-1:0]                  cfg_num_words_in,
    input  logic [CNT_WIDTH-1:0]                  cfg_num_words_out,
    input  logic [PID_WIDTH-1:0]                  cfg_pkt_id,
    input  logic [1:0]                            cfg_dist_mode,
    input  logic [sel_width(NUM_INGRESS_PE)-1:0]  cfg_in_sel,
    input  logic                                  cfg_gather_rr,
    input  logic [sel_width(NUM_EGRESS_PE)-1:0]   cfg_out_sel,
    input  logic                                  in_vld,
    output logic                                  in_rdy,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic [NUM_INGRESS_PE-1:0]             ingress_enqueue,
    output logic [FIFO_WIDTH-1:0]                 ingress_wdata,
    input  logic [NUM_INGRESS_PE-1:0]             ingress_full,
    output logic [NUM_EGRESS_PE-1:0]              egress_dequeue,
    input  logic [FIFO_WIDTH-1:0]                 egress_rdata [NUM_EGRESS_PE],
    input  logic [NUM_EGRESS_PE-1:0]              egress_empty,
    output logic                                  out_vld,
    input  logic                                  out_rdy,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  pkt_ingress_fin,
    output logic                                  kernel_fin,
    output logic                                  busy
);

    localparam int unsigned IN_W  = sel_width(NUM_INGRESS_PE);
    localparam int unsigned OUT_W = sel_width(NUM_EGRESS_PE);

    stream_state_e              in_st, in_st_n, out_st, out_st_n;
    dist_mode_e                 in_mode;
    logic [CNT_WIDTH-1:0]       in_num, out_num, in_cnt, out_cnt;
    logic [PID_WIDTH-1:0]       pkt_id;
    logic                       gather_rr;
    logic [IN_W-1:0]            in_ptr;
    logic [OUT_W-1:0]           out_ptr;
    logic [NUM_INGRESS_PE-1:0]  in_tgt;
    logic                       in_hs, out_hs, start_ok, in_last, out_last;
    logic                       unused_pid;

    assign busy     = (in_st == RUN) || (out_st == RUN);
    assign start_ok = cfg_start && !busy && !cfg_abort;
    assign in_last  = (in_cnt == in_num - 1'b1);
    assign out_last = (out_cnt == out_num - 1'b1);

    spm_rr_ptr #(.N(NUM_INGRESS_PE)) u_in_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_ok),
        .load_val (cfg_in_sel),
        .advance  (in_hs && (in_mode == DIST_RR) && !cfg_abort),
        .ptr      (in_ptr)
    );

    spm_rr_ptr #(.N(NUM_EGRESS_PE)) u_out_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_ok),
        .load_val (cfg_out_sel),
        .advance  (out_hs && gather_rr && !cfg_abort),
        .ptr      (out_ptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_st  <= IDLE;
            out_st <= IDLE;
        end else begin
            in_st  <= in_st_n;
            out_st <= out_st_n;
        end
    end

    always_comb begin
        in_st_n  = in_st;
        out_st_n = out_st;
        if (cfg_abort) begin
            in_st_n  = IDLE;
            out_st_n = IDLE;
        end else if (start_ok) begin
            in_st_n  = RUN;
            out_st_n = RUN;
        end else begin
            if (in_st == RUN && (in_num == '0 || (in_hs && in_last)))
                in_st_n = DONE;
            if (out_st == RUN && (out_num == '0 || (out_hs && out_last)))
                out_st_n = DONE;
        end
    end

    always_comb begin
        in_tgt = '0;
        if (in_st == RUN && in_num != '0) begin
            for (int unsigned i = 0; i < NUM_INGRESS_PE; i++)
                in_tgt[i] = (in_mode == DIST_BCAST) || (in_ptr == IN_W'(i));
        end
        // Any full target stalls the word; broadcast never partially enqueues.
        in_rdy          = (in_tgt != '0) && ((in_tgt & ingress_full) == '0);
        in_hs           = in_vld && in_rdy;
        ingress_enqueue = in_hs ? in_tgt : '0;
        ingress_wdata   = (in_st == RUN) ? FIFO_WIDTH'({pkt_id, in_data}) : '0;

        out_vld                 = (out_st == RUN) && (out_num != '0) && !egress_empty[out_ptr];
        out_hs                  = out_vld && out_rdy;
        egress_dequeue          = '0;
        egress_dequeue[out_ptr] = out_hs;
        out_data                = (out_st == RUN) ? egress_rdata[out_ptr][DATA_WIDTH-1:0] : '0;

        unused_pid = 1'b0;
        for (int unsigned i = 0; i < NUM_EGRESS_PE; i++)
            unused_pid = unused_pid ^ (^egress_rdata[i][FIFO_WIDTH-1:DATA_WIDTH]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_num          <= '0;
            out_num         <= '0;
            in_cnt          <= '0;
            out_cnt         <= '0;
            pkt_id          <= '0;
            in_mode         <= DIST_FIXED;
            gather_rr       <= 1'b0;
            pkt_ingress_fin <= 1'b0;
            kernel_fin      <= 1'b0;
        end else if (cfg_abort) begin
            pkt_ingress_fin <= 1'b0;
            kernel_fin      <= 1'b0;
        end else if (start_ok) begin
            in_num          <= cfg_num_words_in;
            out_num         <= cfg_num_words_out;
            in_cnt          <= '0;
            out_cnt         <= '0;
            pkt_id          <= cfg_pkt_id;
            in_mode         <= dist_mode_e'(cfg_dist_mode);
            gather_rr       <= cfg_gather_rr;
            pkt_ingress_fin <= 1'b0;
            kernel_fin      <= 1'b0;
        end else begin
            if (in_hs)
                in_cnt <= in_cnt + 1'b1;
            if (out_hs)
                out_cnt <= out_cnt + 1'b1;
            if (in_st == RUN && in_st_n == DONE)
                pkt_ingress_fin <= 1'b1;
            if (out_st == RUN && out_st_n == DONE)
                kernel_fin <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spm_stream_ctrl.sv
// Self-checking bench for spm_stream_ctrl: randomized handshakes checked
// against a word-count / channel-arithmetic reference model.
module tb_spm_stream_ctrl;

    localparam int NI = 3;
    localparam int NE = 2;
    localparam int DW = 32;
    localparam int PW = 4;
    localparam int FW = 36;
    localparam int CW = 9;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_start, cfg_abort, cfg_gather_rr;
    logic [CW-1:0]  cfg_num_words_in, cfg_num_words_out;
    logic [PW-1:0]  cfg_pkt_id;
    logic [1:0]     cfg_dist_mode;
    logic [1:0]     cfg_in_sel;
    logic [0:0]     cfg_out_sel;
    logic           in_vld, in_rdy, out_vld, out_rdy;
    logic [DW-1:0]  in_data, out_data;
    logic [NI-1:0]  ingress_enqueue, ingress_full;
    logic [FW-1:0]  ingress_wdata;
    logic [NE-1:0]  egress_dequeue, egress_empty;
    logic [FW-1:0]  egress_rdata [NE];
    logic           pkt_ingress_fin, kernel_fin, busy;

    int checks = 0;
    int errors = 0;

    int m_in_st, m_out_st, m_in_k, m_out_k, m_num_in, m_num_out;
    int m_mode, m_in_sel, m_out_sel, m_rr, m_pid;
    bit m_pfin, m_kfin;

    logic [NI-1:0]  exp_tgt, exp_enq;
    logic           exp_in_rdy, exp_out_vld, exp_busy;
    logic [FW-1:0]  exp_wdata;
    logic [NE-1:0]  exp_deq;
    logic [DW-1:0]  exp_out_data;
    int             exp_ch;

    always #5 clk = ~clk;

    spm_stream_ctrl #(
        .NUM_INGRESS_PE (NI),
        .NUM_EGRESS_PE  (NE),
        .DATA_WIDTH     (DW),
        .PID_WIDTH      (PW),
        .FIFO_WIDTH     (FW),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_start         (cfg_start),
        .cfg_abort         (cfg_abort),
        .cfg_num_words_in  (cfg_num_words_in),
        .cfg_num_words_out (cfg_num_words_out),
        .cfg_pkt_id        (cfg_pkt_id),
        .cfg_dist_mode     (cfg_dist_mode),
        .cfg_in_sel        (cfg_in_sel),
        .cfg_gather_rr     (cfg_gather_rr),
        .cfg_out_sel       (cfg_out_sel),
        .in_vld            (in_vld),
        .in_rdy            (in_rdy),
        .in_data           (in_data),
        .ingress_enqueue   (ingress_enqueue),
        .ingress_wdata     (ingress_wdata),
        .ingress_full      (ingress_full),
        .egress_dequeue    (egress_dequeue),
        .egress_rdata      (egress_rdata),
        .egress_empty      (egress_empty),
        .out_vld           (out_vld),
        .out_rdy           (out_rdy),
        .out_data          (out_data),
        .pkt_ingress_fin   (pkt_ingress_fin),
        .kernel_fin        (kernel_fin),
        .busy              (busy)
    );

    // Expected outputs for the current cycle: word k goes to channel
    // (start + k) mod N in round-robin, start in fixed, every channel in broadcast.
    function automatic void compute_exp();
        int ch;
        exp_tgt = '0;
        if (m_in_st == M_RUN && m_num_in > 0) begin
            if (m_mode == 2) begin
                exp_tgt = '1;
            end else begin
                ch = (m_mode == 1) ? (m_in_sel + m_in_k) % NI : m_in_sel;
                exp_tgt[ch] = 1'b1;
            end
        end
        exp_in_rdy   = (exp_tgt != '0) && ((exp_tgt & ingress_full) == '0);
        exp_enq      = (in_vld && exp_in_rdy) ? exp_tgt : '0;
        exp_wdata    = {PW'(m_pid), in_data};
        exp_ch       = (m_rr != 0) ? (m_out_sel + m_out_k) % NE : m_out_sel;
        exp_out_vld  = (m_out_st == M_RUN) && (m_num_out > 0) && !egress_empty[exp_ch];
        exp_deq      = '0;
        if (exp_out_vld && out_rdy)
            exp_deq[exp_ch] = 1'b1;
        exp_out_data = egress_rdata[exp_ch][DW-1:0];
        exp_busy     = (m_in_st == M_RUN) || (m_out_st == M_RUN);
    endfunction

    // Advance one clock and update the model with this cycle's transfers.
    task automatic tick();
        bit ihs = in_vld && exp_in_rdy;
        bit ohs = exp_out_vld && out_rdy;
        bit st  = cfg_start;
        bit ab  = cfg_abort;
        int c_mode = int'(cfg_dist_mode);
        int c_nin  = int'(cfg_num_words_in);
        int c_nout = int'(cfg_num_words_out);
        int c_isel = int'(cfg_in_sel);
        int c_osel = int'(cfg_out_sel);
        int c_rr   = int'(cfg_gather_rr);
        int c_pid  = int'(cfg_pkt_id);
        @(posedge clk);
        #1;
        if (ab) begin
            m_in_st = M_IDLE; m_out_st = M_IDLE; m_pfin = 0; m_kfin = 0;
        end else if (st && m_in_st != M_RUN && m_out_st != M_RUN) begin
            m_in_st = M_RUN; m_out_st = M_RUN; m_in_k = 0; m_out_k = 0;
            m_pfin = 0; m_kfin = 0;
            m_mode = (c_mode == 3) ? 0 : c_mode;
            m_num_in = c_nin; m_num_out = c_nout;
            m_in_sel = c_isel; m_out_sel = c_osel; m_rr = c_rr; m_pid = c_pid;
        end else begin
            if (m_in_st == M_RUN) begin
                if (ihs) m_in_k++;
                if (m_in_k == m_num_in) begin m_in_st = M_DONE; m_pfin = 1; end
            end
            if (m_out_st == M_RUN) begin
                if (ohs) m_out_k++;
                if (m_out_k == m_num_out) begin m_out_st = M_DONE; m_kfin = 1; end
            end
        end
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
    endtask

    task automatic start_stream(input int mode, input int isel, input int nin,
                                input int rr, input int osel, input int nout, input int pid);
        cfg_dist_mode     = 2'(mode);
        cfg_in_sel        = 2'(isel);
        cfg_num_words_in  = CW'(nin);
        cfg_gather_rr     = (rr != 0);
        cfg_out_sel       = 1'(osel);
        cfg_num_words_out = CW'(nout);
        cfg_pkt_id        = PW'(pid);
        cfg_start         = 1'b1;
        in_vld            = 1'b0;
        out_rdy           = 1'b0;
        @(negedge clk);
        compute_exp();
        tick();
    endtask

    task automatic rand_egress(input int empty_pct);
        for (int i = 0; i < NE; i++) begin
            egress_rdata[i] = {PW'($urandom), DW'($urandom)};
            egress_empty[i] = ($urandom_range(0, 99) < empty_pct);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy got %b exp 0", in_rdy); end
        checks++; if (ingress_enqueue !== '0) begin errors++; $display("FAIL rst_enqueue got %b exp 000", ingress_enqueue); end
        checks++; if (ingress_wdata !== '0) begin errors++; $display("FAIL rst_wdata got %h exp 0", ingress_wdata); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_out_vld got %b exp 0", out_vld); end
        checks++; if (egress_dequeue !== '0) begin errors++; $display("FAIL rst_dequeue got %b exp 00", egress_dequeue); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        checks++; if (pkt_ingress_fin !== 1'b0) begin errors++; $display("FAIL rst_pfin got %b exp 0", pkt_ingress_fin); end
        checks++; if (kernel_fin !== 1'b0) begin errors++; $display("FAIL rst_kfin got %b exp 0", kernel_fin); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fixed();
        int post = 0;
        start_stream(0, 1, 4, 0, 0, 0, 'hA);
        for (int c = 0; c < 100 && post < 3; c++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            in_data = 32'h11 + 32'(m_in_k);
            for (int i = 0; i < NI; i++) ingress_full[i] = ($urandom_range(0, 4) == 0);
            rand_egress(0);
            @(negedge clk);
            compute_exp();
            checks++; if (in_rdy !== exp_in_rdy) begin errors++; $display("FAIL fixed_in_rdy cyc %0d got %b exp %b", c, in_rdy, exp_in_rdy); end
            checks++; if (ingress_enqueue !== exp_enq) begin errors++; $display("FAIL fixed_enqueue cyc %0d got %b exp %b", c, ingress_enqueue, exp_enq); end
            if (exp_enq != '0) begin
                checks++; if (ingress_wdata !== exp_wdata) begin errors++; $display("FAIL fixed_wdata cyc %0d got %h exp %h", c, ingress_wdata, exp_wdata); end
            end
            checks++; if (pkt_ingress_fin !== m_pfin) begin errors++; $display("FAIL fixed_pfin cyc %0d got %b exp %b", c, pkt_ingress_fin, m_pfin); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL fixed_busy cyc %0d got %b exp %b", c, busy, exp_busy); end
            tick();
            if (m_in_st == M_DONE) post++;
        end
        checks++; if (pkt_ingress_fin !== 1'b1) begin errors++; $display("FAIL fixed_done got %b exp 1", pkt_ingress_fin); end
    endtask

    task automatic test_round_robin();
        int post = 0;
        int hold = 0;
        bit held = 0;
        start_stream(1, 2, 7, 0, 0, 0, 'h5);
        for (int c = 0; c < 200 && post < 3; c++) begin
            if (!held && m_in_k == 1) begin hold = 5; held = 1; end
            ingress_full = '0;
            if (hold > 0) begin
                ingress_full[0] = 1'b1;
                hold--;
            end else begin
                ingress_full[1] = ($urandom_range(0, 5) == 0);
            end
            in_vld  = ($urandom_range(0, 4) != 0);
            in_data = $urandom;
            @(negedge clk);
            compute_exp();
            checks++; if (in_rdy !== exp_in_rdy) begin errors++; $display("FAIL rr_in_rdy cyc %0d got %b exp %b", c, in_rdy, exp_in_rdy); end
            checks++; if (ingress_enqueue !== exp_enq) begin errors++; $display("FAIL rr_enqueue cyc %0d got %b exp %b", c, ingress_enqueue, exp_enq); end
            if (exp_enq != '0) begin
                checks++; if (ingress_wdata !== exp_wdata) begin errors++; $display("FAIL rr_wdata cyc %0d got %h exp %h", c, ingress_wdata, exp_wdata); end
            end
            checks++; if (pkt_ingress_fin !== m_pfin) begin errors++; $display("FAIL rr_pfin cyc %0d got %b exp %b", c, pkt_ingress_fin, m_pfin); end
            tick();
            if (m_in_st == M_DONE) post++;
        end
        checks++; if (pkt_ingress_fin !== 1'b1) begin errors++; $display("FAIL rr_done got %b exp 1", pkt_ingress_fin); end
    endtask

    task automatic test_broadcast();
        int post = 0;
        start_stream(2, 0, 2, 0, 0, 0, 'h3);
        for (int c = 0; c < 100 && post < 3; c++) begin
            ingress_full = (c < 6) ? 3'b010 : 3'b000;
            in_vld  = 1'b1;
            in_data = $urandom;
            @(negedge clk);
            compute_exp();
            checks++; if (in_rdy !== exp_in_rdy) begin errors++; $display("FAIL bc_in_rdy cyc %0d got %b exp %b", c, in_rdy, exp_in_rdy); end
            checks++; if (ingress_enqueue !== exp_enq) begin errors++; $display("FAIL bc_enqueue cyc %0d got %b exp %b", c, ingress_enqueue, exp_enq); end
            if (exp_enq != '0) begin
                checks++; if (ingress_wdata !== exp_wdata) begin errors++; $display("FAIL bc_wdata cyc %0d got %h exp %h", c, ingress_wdata, exp_wdata); end
            end
            checks++; if (pkt_ingress_fin !== m_pfin) begin errors++; $display("FAIL bc_pfin cyc %0d got %b exp %b", c, pkt_ingress_fin, m_pfin); end
            tick();
            if (m_in_st == M_DONE) post++;
        end
        checks++; if (pkt_ingress_fin !== 1'b1) begin errors++; $display("FAIL bc_done got %b exp 1", pkt_ingress_fin); end
    endtask

    task automatic test_gather();
        for (int it = 0; it < 4; it++) begin
            int post = 0;
            if (it == 0) start_stream(0, 0, 0, 1, 0, 4, 0);
            else start_stream(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 6), 0);
            for (int c = 0; c < 200 && post < 3; c++) begin
                in_vld = 1'b0;
                if (it == 0) begin
                    rand_egress(0);
                    out_rdy = (c % 2 == 0);
                end else begin
                    rand_egress(35);
                    out_rdy = ($urandom_range(0, 2) != 0);
                end
                @(negedge clk);
                compute_exp();
                checks++; if (out_vld !== exp_out_vld) begin errors++; $display("FAIL gather_out_vld it %0d cyc %0d got %b exp %b", it, c, out_vld, exp_out_vld); end
                checks++; if (egress_dequeue !== exp_deq) begin errors++; $display("FAIL gather_dequeue it %0d cyc %0d got %b exp %b", it, c, egress_dequeue, exp_deq); end
                if (exp_out_vld) begin
                    checks++; if (out_data !== exp_out_data) begin errors++; $display("FAIL gather_out_data it %0d cyc %0d got %h exp %h", it, c, out_data, exp_out_data); end
                end
                checks++; if (kernel_fin !== m_kfin) begin errors++; $display("FAIL gather_kfin it %0d cyc %0d got %b exp %b", it, c, kernel_fin, m_kfin); end
                checks++; if (busy !== exp_busy) begin errors++; $display("FAIL gather_busy it %0d cyc %0d got %b exp %b", it, c, busy, exp_busy); end
                tick();
                if (m_out_st == M_DONE) post++;
            end
            checks++; if (kernel_fin !== 1'b1) begin errors++; $display("FAIL gather_done it %0d got %b exp 1", it, kernel_fin); end
        end
    endtask

    task automatic test_zero_count();
        start_stream(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            in_vld = 1'b1; out_rdy = 1'b1; ingress_full = '0;
            rand_egress(0);
            @(negedge clk);
            compute_exp();
            checks++; if (in_rdy !== exp_in_rdy) begin errors++; $display("FAIL zero_in_rdy cyc %0d got %b exp %b", c, in_rdy, exp_in_rdy); end
            checks++; if (ingress_enqueue !== exp_enq) begin errors++; $display("FAIL zero_enqueue cyc %0d got %b exp %b", c, ingress_enqueue, exp_enq); end
            checks++; if (egress_dequeue !== exp_deq) begin errors++; $display("FAIL zero_dequeue cyc %0d got %b exp %b", c, egress_dequeue, exp_deq); end
            checks++; if (pkt_ingress_fin !== m_pfin) begin errors++; $display("FAIL zero_pfin cyc %0d got %b exp %b", c, pkt_ingress_fin, m_pfin); end
            checks++; if (kernel_fin !== m_kfin) begin errors++; $display("FAIL zero_kfin cyc %0d got %b exp %b", c, kernel_fin, m_kfin); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL zero_busy cyc %0d got %b exp %b", c, busy, exp_busy); end
            tick();
        end
    endtask

    task automatic test_abort();
        start_stream(0, 0, 5, 0, 1, 5, 'h3);
        for (int c = 0; c < 6; c++) begin
            cfg_start = (c == 1);
            if (c == 1) begin cfg_dist_mode = 2'd2; cfg_num_words_in = CW'(1); cfg_in_sel = 2'd2; end
            cfg_abort    = (c == 2);
            in_vld       = (c != 2);
            in_data      = $urandom;
            ingress_full = '0;
            out_rdy      = 1'b1;
            rand_egress(100);
            @(negedge clk);
            compute_exp();
            checks++; if (in_rdy !== exp_in_rdy) begin errors++; $display("FAIL abort_in_rdy cyc %0d got %b exp %b", c, in_rdy, exp_in_rdy); end
            checks++; if (ingress_enqueue !== exp_enq) begin errors++; $display("FAIL abort_enqueue cyc %0d got %b exp %b", c, ingress_enqueue, exp_enq); end
            checks++; if (pkt_ingress_fin !== m_pfin) begin errors++; $display("FAIL abort_pfin cyc %0d got %b exp %b", c, pkt_ingress_fin, m_pfin); end
            checks++; if (kernel_fin !== m_kfin) begin errors++; $display("FAIL abort_kfin cyc %0d got %b exp %b", c, kernel_fin, m_kfin); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL abort_busy cyc %0d got %b exp %b", c, busy, exp_busy); end
            tick();
        end
    endtask

    task automatic test_reset_mid_stream();
        start_stream(1, 0, 7, 1, 0, 3, 'h5);
        for (int c = 0; c < 3; c++) begin
            in_vld = 1'b1; in_data = $urandom; out_rdy = 1'b1; ingress_full = '0;
            rand_egress(0);
            @(negedge clk);
            compute_exp();
            checks++; if (ingress_enqueue !== exp_enq) begin errors++; $display("FAIL midrst_enqueue cyc %0d got %b exp %b", c, ingress_enqueue, exp_enq); end
            checks++; if (egress_dequeue !== exp_deq) begin errors++; $display("FAIL midrst_dequeue cyc %0d got %b exp %b", c, egress_dequeue, exp_deq); end
            tick();
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL midrst_in_rdy got %b exp 0", in_rdy); end
        checks++; if (ingress_enqueue !== '0) begin errors++; $display("FAIL midrst_enq_zero got %b exp 000", ingress_enqueue); end
        checks++; if (ingress_wdata !== '0) begin errors++; $display("FAIL midrst_wdata got %h exp 0", ingress_wdata); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL midrst_out_vld got %b exp 0", out_vld); end
        checks++; if (egress_dequeue !== '0) begin errors++; $display("FAIL midrst_deq_zero got %b exp 00", egress_dequeue); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL midrst_out_data got %h exp 0", out_data); end
        checks++; if (pkt_ingress_fin !== 1'b0) begin errors++; $display("FAIL midrst_pfin got %b exp 0", pkt_ingress_fin); end
        checks++; if (kernel_fin !== 1'b0) begin errors++; $display("FAIL midrst_kfin got %b exp 0", kernel_fin); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        m_in_st = M_IDLE; m_out_st = M_IDLE; m_pfin = 0; m_kfin = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_mix();
        for (int s = 0; s < 6; s++) begin
            int post = 0;
            start_stream($urandom_range(0, 3), $urandom_range(0, NI - 1), $urandom_range(0, 10),
                         $urandom_range(0, 1), $urandom_range(0, NE - 1), $urandom_range(0, 10),
                         $urandom_range(0, 15));
            for (int c = 0; c < 300 && post < 2; c++) begin
                in_vld  = ($urandom_range(0, 3) != 0);
                in_data = $urandom;
                out_rdy = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < NI; i++) ingress_full[i] = ($urandom_range(0, 4) == 0);
                rand_egress(30);
                @(negedge clk);
                compute_exp();
                checks++; if (in_rdy !== exp_in_rdy) begin errors++; $display("FAIL mix_in_rdy s %0d cyc %0d got %b exp %b", s, c, in_rdy, exp_in_rdy); end
                checks++; if (ingress_enqueue !== exp_enq) begin errors++; $display("FAIL mix_enqueue s %0d cyc %0d got %b exp %b", s, c, ingress_enqueue, exp_enq); end
                if (exp_enq != '0) begin
                    checks++; if (ingress_wdata !== exp_wdata) begin errors++; $display("FAIL mix_wdata s %0d cyc %0d got %h exp %h", s, c, ingress_wdata, exp_wdata); end
                end
                checks++; if (out_vld !== exp_out_vld) begin errors++; $display("FAIL mix_out_vld s %0d cyc %0d got %b exp %b", s, c, out_vld, exp_out_vld); end
                checks++; if (egress_dequeue !== exp_deq) begin errors++; $display("FAIL mix_dequeue s %0d cyc %0d got %b exp %b", s, c, egress_dequeue, exp_deq); end
                if (exp_out_vld) begin
                    checks++; if (out_data !== exp_out_data) begin errors++; $display("FAIL mix_out_data s %0d cyc %0d got %h exp %h", s, c, out_data, exp_out_data); end
                end
                checks++; if (pkt_ingress_fin !== m_pfin) begin errors++; $display("FAIL mix_pfin s %0d cyc %0d got %b exp %b", s, c, pkt_ingress_fin, m_pfin); end
                checks++; if (kernel_fin !== m_kfin) begin errors++; $display("FAIL mix_kfin s %0d cyc %0d got %b exp %b", s, c, kernel_fin, m_kfin); end
                checks++; if (busy !== exp_busy) begin errors++; $display("FAIL mix_busy s %0d cyc %0d got %b exp %b", s, c, busy, exp_busy); end
                tick();
                if (m_in_st != M_RUN && m_out_st != M_RUN) post++;
            end
            checks++; if (pkt_ingress_fin !== 1'b1) begin errors++; $display("FAIL mix_in_done s %0d got %b exp 1", s, pkt_ingress_fin); end
            checks++; if (kernel_fin !== 1'b1) begin errors++; $display("FAIL mix_out_done s %0d got %b exp 1", s, kernel_fin); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit reached");
    end

    initial begin
        cfg_start = 1'b0; cfg_abort = 1'b0; cfg_gather_rr = 1'b0;
        cfg_num_words_in = '0; cfg_num_words_out = '0; cfg_pkt_id = '0;
        cfg_dist_mode = '0; cfg_in_sel = '0; cfg_out_sel = '0;
        in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
        ingress_full = '0; egress_empty = '1;
        for (int i = 0; i < NE; i++) egress_rdata[i] = '0;
        m_in_st = M_IDLE; m_out_st = M_IDLE; m_in_k = 0; m_out_k = 0;
        m_num_in = 0; m_num_out = 0; m_mode = 0; m_in_sel = 0; m_out_sel = 0;
        m_rr = 0; m_pid = 0; m_pfin = 0; m_kfin = 0;

        test_reset();
        test_fixed();
        test_round_robin();
        test_broadcast();
        test_gather();
        test_zero_count();
        test_abort();
        test_reset_mid_stream();
        test_random_mix();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
